// File: rtl/tri_row_server_pkg.sv
// Shared types and helpers for the lower-triangular row server.
package tri_row_server_pkg;

   localparam int unsigned DefWidth = 64;

   typedef enum logic {StLoad, StServe} state_e;

   // Field "re" holds the real part; "real" is a reserved word.
   typedef struct packed {
      logic [DefWidth-1:0] im;
      logic [DefWidth-1:0] re;
   } cplx_t;

   // Bit offset of element j inside a packed row of {imag, real} pairs.
   function automatic int unsigned elem_lsb(input int unsigned j, input int unsigned width);
      return j * 2 * width;
   endfunction

endpackage

// File: rtl/tri_row_mem.sv
// Row storage: one write port, one registered read port with hold and out-of-range zeroing.
module tri_row_mem #(
   parameter int unsigned SIZE  = 16,
   parameter int unsigned ROW_W = 2048,
   localparam int unsigned Aw   = $clog2(SIZE)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             we_i,
   input  logic [Aw-1:0]    waddr_i,
   input  logic [ROW_W-1:0] wdata_i,
   input  logic             re_i,
   input  logic [Aw-1:0]    raddr_i,
   output logic [ROW_W-1:0] rdata_o
);

   localparam logic [Aw:0] SizeExt = (Aw+1)'(SIZE);

   logic [ROW_W-1:0] mem_q [SIZE];
   logic [ROW_W-1:0] rdata_q;
   logic             in_range;

   assign in_range = ({1'b0, raddr_i} < SizeExt);

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Only the read register is reset; the array keeps its contents.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= in_range ? mem_q[raddr_i] : '0;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/tri_row_server.sv
// Loads a lower-triangular complex matrix row by row, then serves rows to the inverter.
module tri_row_server
   import tri_row_server_pkg::*;
#(
   parameter int unsigned SIZE  = 16,
   parameter int unsigned WIDTH = 64
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [SIZE*2*WIDTH-1:0]   load_row_i,
   input  logic                      load_valid_i,
   output logic                      load_ready_o,
   input  logic [$clog2(SIZE)-1:0]   mat_row_addr_i,
   input  logic                      mat_row_addr_valid_i,
   output logic [SIZE*2*WIDTH-1:0]   mat_row_o,
   output logic [$clog2(SIZE)-1:0]   mat_row_addr_o,
   output logic                      mat_row_valid_o,
   output logic                      start_o,
   input  logic                      flush_i,
   output logic                      diag_err_o,
   output logic                      req_err_o,
   output logic                      busy_o
);

   localparam int unsigned Aw      = $clog2(SIZE);
   localparam int unsigned RowW    = SIZE * 2 * WIDTH;
   localparam logic [Aw-1:0] LastRow = Aw'(SIZE - 1);

   state_e          state_q, state_d;
   logic [Aw-1:0]   cnt_q, cnt_d;
   logic [Aw-1:0]   addr_q, addr_d;
   logic            start_q, start_d;
   logic            valid_q, valid_d;
   logic            diag_err_q, diag_err_d;
   logic            req_err_q, req_err_d;
   logic            accept, rd_en, diag_zero;
   logic [RowW-1:0] wdata;
   logic [WIDTH-2:0] diag_re_mag, diag_im_mag;

   assign load_ready_o = (state_q == StLoad);
   assign busy_o       = (state_q == StServe);
   assign accept       = load_valid_i && load_ready_o && !flush_i;
   assign rd_en        = mat_row_addr_valid_i && busy_o && !flush_i;

   // Everything right of the diagonal is forced to zero before storage.
   always_comb begin
      wdata = load_row_i;
      for (int unsigned j = 0; j < SIZE; j++) begin
         if (j > 32'(cnt_q)) begin
            wdata[elem_lsb(j, WIDTH) +: 2*WIDTH] = '0;
         end
      end
   end

   // Sign bit ignored: +0 and -0 both count as a zero diagonal.
   assign diag_re_mag = load_row_i[elem_lsb(32'(cnt_q), WIDTH) +: WIDTH-1];
   assign diag_im_mag = load_row_i[elem_lsb(32'(cnt_q), WIDTH) + WIDTH +: WIDTH-1];
   assign diag_zero   = (diag_re_mag == '0) && (diag_im_mag == '0);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      start_d    = 1'b0;
      valid_d    = 1'b0;
      diag_err_d = diag_err_q;
      req_err_d  = req_err_q;
      if (flush_i) begin
         state_d    = StLoad;
         cnt_d      = '0;
         diag_err_d = 1'b0;
         req_err_d  = 1'b0;
      end else begin
         unique case (state_q)
            StLoad: begin
               if (mat_row_addr_valid_i) begin
                  req_err_d = 1'b1;
               end
               if (accept) begin
                  if (diag_zero) begin
                     diag_err_d = 1'b1;
                  end
                  if (cnt_q == LastRow) begin
                     state_d = StServe;
                     cnt_d   = '0;
                     start_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            StServe: begin
               if (mat_row_addr_valid_i) begin
                  valid_d = 1'b1;
                  addr_d  = mat_row_addr_i;
               end
            end
            default: state_d = StLoad;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StLoad;
         cnt_q      <= '0;
         addr_q     <= '0;
         start_q    <= 1'b0;
         valid_q    <= 1'b0;
         diag_err_q <= 1'b0;
         req_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         start_q    <= start_d;
         valid_q    <= valid_d;
         diag_err_q <= diag_err_d;
         req_err_q  <= req_err_d;
      end
   end

   tri_row_mem #(
      .SIZE  (SIZE),
      .ROW_W (RowW)
   ) u_mem (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (accept && !rst_i),
      .waddr_i (cnt_q),
      .wdata_i (wdata),
      .re_i    (rd_en),
      .raddr_i (mat_row_addr_i),
      .rdata_o (mat_row_o)
   );

   assign mat_row_addr_o  = addr_q;
   assign mat_row_valid_o = valid_q;
   assign start_o         = start_q;
   assign diag_err_o      = diag_err_q;
   assign req_err_o       = req_err_q;

endmodule

// File: tb/tb_tri_row_server.sv
// Self-checking bench for tri_row_server: directed table, corner sequences, random vs model.
module tb_tri_row_server;

   localparam int unsigned SIZE  = 16;
   localparam int unsigned WIDTH = 64;
   localparam int unsigned AW    = 4;
   localparam int unsigned ROW_W = SIZE * 2 * WIDTH;
   localparam logic [63:0] ONE   = 64'h3FF0_0000_0000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, load_valid, addr_valid, flush;
   logic [ROW_W-1:0] load_row;
   logic [AW-1:0]    req_addr;
   logic             load_ready, row_valid, start, diag_err, req_err, busy;
   logic [ROW_W-1:0] row_out;
   logic [AW-1:0]    row_addr;

   tri_row_server #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
      .clk_i                (clk),
      .rst_i                (rst),
      .load_row_i           (load_row),
      .load_valid_i         (load_valid),
      .load_ready_o         (load_ready),
      .mat_row_addr_i       (req_addr),
      .mat_row_addr_valid_i (addr_valid),
      .mat_row_o            (row_out),
      .mat_row_addr_o       (row_addr),
      .mat_row_valid_o      (row_valid),
      .start_o              (start),
      .flush_i              (flush),
      .diag_err_o           (diag_err),
      .req_err_o            (req_err),
      .busy_o               (busy)
   );

   // Small non-power-of-2 instance for out-of-range addresses.
   logic        s_rst, s_lv, s_av, s_fl;
   logic [47:0] s_lrow, s_row;
   logic [1:0]  s_ra, s_addr;
   logic        s_ready, s_valid, s_start, s_derr, s_rerr, s_busy;

   tri_row_server #(.SIZE(3), .WIDTH(8)) dut_small (
      .clk_i                (clk),
      .rst_i                (s_rst),
      .load_row_i           (s_lrow),
      .load_valid_i         (s_lv),
      .load_ready_o         (s_ready),
      .mat_row_addr_i       (s_ra),
      .mat_row_addr_valid_i (s_av),
      .mat_row_o            (s_row),
      .mat_row_addr_o       (s_addr),
      .mat_row_valid_o      (s_valid),
      .start_o              (s_start),
      .flush_i              (s_fl),
      .diag_err_o           (s_derr),
      .req_err_o            (s_rerr),
      .busy_o               (s_busy)
   );

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [ROW_W-1:0] m_rows [SIZE];
   bit               m_loading;
   int               m_cnt;
   logic             e_valid, e_start, e_diag, e_req;
   logic [ROW_W-1:0] e_row;
   logic [AW-1:0]    e_addr;

   typedef struct {
      logic [AW-1:0] addr;
      int            nz;
   } vec_t;
   vec_t tbl [6] = '{'{4'd3, 4}, '{4'd0, 1}, '{4'd15, 16}, '{4'd7, 8}, '{4'd12, 13}, '{4'd1, 2}};

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic chk_row(input string name, input logic [ROW_W-1:0] act,
                          input logic [ROW_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         for (int j = 0; j < SIZE; j++) begin
            if (act[j*2*WIDTH +: 2*WIDTH] !== exp[j*2*WIDTH +: 2*WIDTH]) begin
               $display("FAIL %s: element %0d got %h want %h", name, j,
                        act[j*2*WIDTH +: 2*WIDTH], exp[j*2*WIDTH +: 2*WIDTH]);
               break;
            end
         end
      end
   endtask

   function automatic logic [ROW_W-1:0] mk_row(input logic [63:0] re, input logic [63:0] im);
      logic [ROW_W-1:0] r;
      for (int j = 0; j < SIZE; j++) begin
         r[j*2*WIDTH +: 2*WIDTH] = {im, re};
      end
      return r;
   endfunction

   // Rules applied to the inputs sampled at the edge just taken.
   task automatic model_step();
      logic [ROW_W-1:0] r;
      real              d_re, d_im;
      if (rst) begin
         m_loading = 1'b1; m_cnt = 0;
         e_valid = 0; e_start = 0; e_diag = 0; e_req = 0; e_row = '0; e_addr = '0;
         return;
      end
      e_valid = 0;
      e_start = 0;
      if (flush) begin
         m_loading = 1'b1; m_cnt = 0; e_diag = 0; e_req = 0;
         return;
      end
      if (m_loading) begin
         if (addr_valid) e_req = 1;
         if (load_valid) begin
            r = load_row;
            for (int j = m_cnt + 1; j < SIZE; j++) r[j*2*WIDTH +: 2*WIDTH] = '0;
            d_re = $bitstoreal(load_row[m_cnt*2*WIDTH +: 64]);
            d_im = $bitstoreal(load_row[m_cnt*2*WIDTH+WIDTH +: 64]);
            if (d_re == 0.0 && d_im == 0.0) e_diag = 1;
            m_rows[m_cnt] = r;
            m_cnt++;
            if (m_cnt == SIZE) begin
               m_loading = 1'b0; m_cnt = 0; e_start = 1;
            end
         end
      end else if (addr_valid) begin
         e_valid = 1;
         e_addr  = req_addr;
         e_row   = m_rows[req_addr];
      end
   endtask

   task automatic step(input logic r, input logic lv, input logic [ROW_W-1:0] row,
                       input logic av, input logic [AW-1:0] a, input logic fl);
      rst = r; load_valid = lv; load_row = row; addr_valid = av; req_addr = a; flush = fl;
      @(posedge clk);
      model_step();
      #1;
      chk("valid", row_valid, e_valid);
      chk("start", start, e_start);
      chk("diag_err", diag_err, e_diag);
      chk("req_err", req_err, e_req);
      chk("load_ready", load_ready, m_loading);
      chk("busy", busy, !m_loading);
      chk("row_addr", row_addr, e_addr);
      chk_row("row", row_out, e_row);
   endtask

   task automatic idle();
      step(0, 0, '0, 0, '0, 0);
   endtask

   task automatic beat(input logic [ROW_W-1:0] row);
      step(0, 1, row, 0, '0, 0);
   endtask

   task automatic req(input logic [AW-1:0] a);
      step(0, 0, '0, 1, a, 0);
   endtask

   task automatic do_flush();
      step(0, 0, '0, 0, '0, 1);
   endtask

   task automatic load_n(input int n, output int starts, output int at);
      starts = 0;
      at     = -1;
      for (int i = 0; i < n; i++) begin
         beat(mk_row(ONE, ONE));
         if (start === 1'b1) begin
            starts++;
            at = i + 1;
         end
      end
   endtask

   initial begin
      int               n, at, nz, zr;
      logic [ROW_W-1:0] r;
      logic             lv, av, fl, rs;
      logic [AW-1:0]    a;

      s_rst = 0; s_lv = 0; s_av = 0; s_fl = 0; s_lrow = '0; s_ra = '0;

      step(1, 0, '0, 0, '0, 0);
      step(1, 1, mk_row(ONE, ONE), 1, 4'd3, 0);
      chk("rst_ready", load_ready, 1);
      chk("rst_busy", busy, 0);

      // Full load of 1.0+1.0i: single start pulse right after beat 16
      load_n(16, n, at);
      chk("start_count", n, 1);
      chk("start_beat", at, 16);
      idle();
      chk("start_once", start, 0);

      // Table: row addr -> number of 1.0+1.0i elements, rest zero
      for (int i = 0; i < 6; i++) begin
         req(tbl[i].addr);
         nz = 0;
         zr = 0;
         for (int j = 0; j < SIZE; j++) begin
            if (row_out[j*2*WIDTH +: 2*WIDTH] == {ONE, ONE}) nz++;
            if (row_out[j*2*WIDTH +: 2*WIDTH] == '0) zr++;
         end
         chk("tbl_valid", row_valid, 1);
         chk("tbl_addr", row_addr, tbl[i].addr);
         chk("tbl_nz", nz, tbl[i].nz);
         chk("tbl_zero", zr, SIZE - tbl[i].nz);
      end

      // Back-to-back requests 0..15
      for (int i = 0; i < SIZE; i++) begin
         req(AW'(i));
         chk("b2b_valid", row_valid, 1);
         chk("b2b_addr", row_addr, i);
      end
      idle();
      chk("b2b_idle", row_valid, 0);

      // Flush coincident with a request in SERVE
      step(0, 0, '0, 1, 4'd2, 1);
      chk("flush_req_valid", row_valid, 0);
      chk("flush_req_busy", busy, 0);

      // Request during LOAD
      req(4'd5);
      chk("load_req_valid", row_valid, 0);
      chk("load_req_err", req_err, 1);
      idle();
      idle();
      chk("req_err_sticky", req_err, 1);
      do_flush();
      chk("req_err_clr", req_err, 0);

      // Zero diagonal on row 7 (0.0 - 0.0i)
      load_n(7, n, at);
      r = mk_row(ONE, ONE);
      r[7*2*WIDTH +: 64]         = 64'h0;
      r[7*2*WIDTH + WIDTH +: 64] = 64'h8000_0000_0000_0000;
      beat(r);
      chk("diag_set", diag_err, 1);
      idle();
      chk("diag_sticky", diag_err, 1);
      do_flush();
      chk("diag_clr", diag_err, 0);
      chk("diag_ready", load_ready, 1);
      load_n(16, n, at);
      chk("after_flush_start", at, 16);

      // Flush coincident with beat 16
      do_flush();
      load_n(15, n, at);
      chk("pre16_starts", n, 0);
      step(0, 1, mk_row(ONE, ONE), 0, '0, 1);
      chk("flush16_start", start, 0);
      idle();
      chk("flush16_start_late", start, 0);
      load_n(16, n, at);
      chk("flush16_restart", at, 16);

      // Reset after 9 rows
      do_flush();
      load_n(9, n, at);
      step(1, 0, '0, 0, '0, 0);
      load_n(15, n, at);
      chk("rst9_no_start", n, 0);
      load_n(1, n, at);
      chk("rst9_start", n, 1);

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < ROW_W / 32; k++) r[k*32 +: 32] = $urandom;
         if ($urandom_range(7) == 0 && m_loading) begin
            r[m_cnt*2*WIDTH +: 64]         = {1'($urandom_range(1)), 63'b0};
            r[m_cnt*2*WIDTH + WIDTH +: 64] = {1'($urandom_range(1)), 63'b0};
         end
         rs = ($urandom_range(499) == 0);
         fl = ($urandom_range(24) == 0);
         lv = ($urandom_range(3) != 0);
         av = 1'($urandom_range(1));
         a  = AW'($urandom_range(SIZE - 1));
         step(rs, lv, r, av, a, fl);
      end
      rst = 0; load_valid = 0; addr_valid = 0; flush = 0;

      // SIZE=3 instance: out-of-range address and triangular masking
      s_rst = 1;
      @(posedge clk); #1;
      s_rst = 0;
      s_lrow = {48{1'b1}};
      s_lv = 1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
      end
      s_lv = 0;
      chk("s_start", s_start, 1);
      s_av = 1; s_ra = 2'd3;
      @(posedge clk); #1;
      chk("s_oob_valid", s_valid, 1);
      chk("s_oob_addr", s_addr, 3);
      chk("s_oob_row", s_row, 48'h0);
      s_ra = 2'd1;
      @(posedge clk); #1;
      chk("s_row1", s_row, 48'h0000_FFFF_FFFF);
      s_ra = 2'd2;
      @(posedge clk); #1;
      chk("s_row2", s_row, 48'hFFFF_FFFF_FFFF);
      s_ra = 2'd0;
      @(posedge clk); #1;
      chk("s_row0", s_row, 48'h0000_0000_FFFF);
      s_av = 0;
      @(posedge clk); #1;
      chk("s_idle_valid", s_valid, 0);
      chk("s_hold_row", s_row, 48'h0000_0000_FFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
